// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between an upstream FIFO and the UART transmitter.
// The transmitter is the master: it issues the read strobe and consumes flag/data.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rden;

  modport master (input fifo_empty, input fifo_dout, output fifo_rden);
  modport slave  (output fifo_empty, output fifo_dout, input fifo_rden);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pulls bytes from a FIFO read port and sends each as an 8N1 UART frame, LSB first.
// state | meaning
// IDLE  | line high, waiting for tx_en with a non-empty FIFO
// FETCH | one-cycle read strobe to the FIFO
// LATCH | FIFO data valid, captured into the shift register
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); last cycle pulses tx_done
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            rdclk,
  input  logic            rdrst,
  input  logic            tx_en,
  fifo_uart_tx_if.master  fifo,
  output logic            tx,
  output logic            busy,
  output logic            tx_done,
  output logic [15:0]     frame_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        tx_q, tx_d;
  logic        arm_q, arm_d;
  logic        bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge rdclk or posedge rdrst) begin
    if (rdrst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_cnt_q <= '0;
      tx_q        <= 1'b1;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_cnt_q <= frame_cnt_d;
      tx_q        <= tx_d;
      arm_q       <= arm_d;
    end
  end

  // arm_q holds off the first fetch until one full cycle after reset release
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    frame_cnt_d = frame_cnt_q;
    arm_d       = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        if (arm_q && tx_en && !fifo.fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        baud_d  = '0;
        state_d = LATCH;
      end
      LATCH: begin
        baud_d  = '0;
        shreg_d = fifo.fifo_dout;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d    = '0;
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d      = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    // tx is registered: compute the level the line should carry in the next state
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    fifo.fifo_rden = (state_q == FETCH);
    busy           = (state_q != IDLE);
    tx_done        = (state_q == STOP) && bit_end;
    tx             = tx_q;
    frame_cnt      = frame_cnt_q;
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized bench for fifo_uart_tx: a FIFO model feeds the DUT, a line decoder
// reconstructs frames and checks them against a queue of expected bytes.
`timescale 1ns/1ns
module tb_fifo_uart_tx;
  localparam int N = 4;

  logic        rdclk = 1'b0;
  logic        wrclk = 1'b0;
  logic        rdrst = 1'b1;
  logic        tx_en = 1'b0;
  logic        tx, busy, tx_done;
  logic [15:0] frame_cnt;

  fifo_uart_tx_if ifc ();

  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic [7:0] dout_v = 8'd0;
  logic       take;

  assign ifc.fifo_empty = (wr_ptr == rd_ptr);
  assign ifc.fifo_dout  = dout_v;

  fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .rdclk     (rdclk),
    .rdrst     (rdrst),
    .tx_en     (tx_en),
    .fifo      (ifc),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .frame_cnt (frame_cnt)
  );

  // rdclk 50 kHz, wrclk 200 kHz; phases chosen so their edges never coincide
  initial forever #10000 rdclk = ~rdclk;
  initial begin
    #1250;
    forever #2500 wrclk = ~wrclk;
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q [$];
  int         rden_cnt = 0, done_cnt = 0, busy_cyc = 0, txlow_cyc = 0, cyc = 0;
  int         rden_cyc [$];

  // FIFO read side: data appears the cycle after an accepted read strobe
  initial forever begin
    @(negedge rdclk);
    take = ifc.fifo_rden && !ifc.fifo_empty;
    @(posedge rdclk);
    #1;
    if (take) begin
      dout_v = mem[rd_ptr];
      rd_ptr = 8'(rd_ptr + 8'd1);
    end
  end

  // Monitor: line decoder + activity counters, sampled mid-cycle
  logic       dec_on = 1'b0, dec_have, dec_bad, lvl;
  int         dec_cnt, k;
  logic [7:0] dec_exp, dec_byte;

  initial forever begin
    @(negedge rdclk);
    cyc++;
    if (busy) busy_cyc++;
    if (tx_done) done_cnt++;
    if (!tx) txlow_cyc++;
    if (ifc.fifo_rden) begin
      rden_cnt++;
      rden_cyc.push_back(cyc);
      tests++;
      if (ifc.fifo_empty) begin
        fails++;
        $display("FAIL rden_on_empty: fifo_rden=1 with fifo_empty=1 at cycle %0d", cyc);
      end
    end
    if (rdrst) begin
      dec_on = 1'b0;
    end else begin
      if (!dec_on && tx == 1'b0) begin
        dec_on   = 1'b1;
        dec_cnt  = 0;
        dec_have = (exp_q.size() > 0);
        dec_exp  = dec_have ? exp_q[0] : 8'h00;
        dec_bad  = 1'b0;
        dec_byte = 8'h00;
      end
      if (dec_on) begin
        k = dec_cnt / N;
        if (k == 0) lvl = 1'b0;
        else if (k <= 8) lvl = dec_exp[k-1];
        else lvl = 1'b1;
        if (tx != lvl) dec_bad = 1'b1;
        if ((dec_cnt % N) == N / 2 && k >= 1 && k <= 8) dec_byte[k-1] = tx;
        if (dec_cnt == 10 * N - 1) begin
          tests++;
          if (!dec_have) begin
            fails++;
            $display("FAIL frame_unexpected: got byte %02h, expected no frame", dec_byte);
          end else if (dec_byte != dec_exp) begin
            fails++;
            $display("FAIL frame_byte: got %02h expected %02h", dec_byte, dec_exp);
          end
          tests++;
          if (dec_bad) begin
            fails++;
            $display("FAIL frame_shape: line levels wrong for byte %02h (got bad=1 expected 0)", dec_exp);
          end
          if (dec_have) void'(exp_q.pop_front());
          dec_on = 1'b0;
        end
        dec_cnt++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(posedge wrclk);
    mem[wr_ptr] = b;
    wr_ptr      = 8'(wr_ptr + 8'd1);
    exp_q.push_back(b);
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    for (int i = 0; i < budget && int'(frame_cnt) != target; i++) @(negedge rdclk);
    chk(name, int'(frame_cnt), target);
  endtask

  task automatic wait_tx_low(input string name, input int budget);
    for (int i = 0; i < budget && tx != 1'b0; i++) @(negedge rdclk);
    chk(name, int'(tx), 0);
  endtask

  task automatic do_reset();
    tx_en = 1'b0;
    @(negedge rdclk);
    #2500 rdrst = 1'b1;
    #1;
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    repeat (2) @(negedge rdclk);
    #2500 rdrst = 1'b0;
    repeat (2) @(negedge rdclk);
  endtask

  int r0, d0, b0, t0, q0;

  initial begin
    // reset held from time zero
    repeat (2) @(negedge rdclk);
    #1;
    chk("reset_tx", int'(tx), 1);
    chk("reset_rden", int'(ifc.fifo_rden), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_tx_done", int'(tx_done), 0);
    chk("reset_frame_cnt", int'(frame_cnt), 0);

    // single byte 0xA5
    do_reset();
    r0 = rden_cnt; d0 = done_cnt; b0 = busy_cyc;
    push_byte(8'hA5);
    tx_en = 1'b1;
    wait_frames("a5_frame_cnt", 1, 200);
    repeat (5) @(negedge rdclk);
    chk("a5_rden_cycles", rden_cnt - r0, 1);
    chk("a5_tx_done", done_cnt - d0, 1);
    chk("a5_busy_cycles", busy_cyc - b0, 42);
    chk("a5_exp_left", exp_q.size(), 0);

    // back-to-back 0x01 0x80 0xFF
    do_reset();
    r0 = rden_cnt; q0 = rden_cyc.size();
    push_byte(8'h01); push_byte(8'h80); push_byte(8'hFF);
    tx_en = 1'b1;
    wait_frames("b2b_frame_cnt", 3, 300);
    repeat (5) @(negedge rdclk);
    chk("b2b_rden", rden_cnt - r0, 3);
    if (rden_cyc.size() >= q0 + 3) begin
      chk("b2b_gap1", rden_cyc[q0+1] - rden_cyc[q0], 43);
      chk("b2b_gap2", rden_cyc[q0+2] - rden_cyc[q0+1], 43);
    end
    chk("b2b_exp_left", exp_q.size(), 0);

    // empty FIFO with tx_en high
    do_reset();
    r0 = rden_cnt; b0 = busy_cyc; t0 = txlow_cyc;
    tx_en = 1'b1;
    repeat (100) @(negedge rdclk);
    chk("empty_rden", rden_cnt - r0, 0);
    chk("empty_busy", busy_cyc - b0, 0);
    chk("empty_tx_low", txlow_cyc - t0, 0);

    // tx_en dropped during DATA of frame 1
    do_reset();
    r0 = rden_cnt;
    push_byte(8'($urandom_range(0, 255)));
    push_byte(8'($urandom_range(0, 255)));
    tx_en = 1'b1;
    wait_tx_low("drop_start", 50);
    repeat (N + 2) @(negedge rdclk);
    tx_en = 1'b0;
    repeat (150) @(negedge rdclk);
    chk("drop_frame_cnt", int'(frame_cnt), 1);
    chk("drop_rden", rden_cnt - r0, 1);
    chk("drop_exp_pending", exp_q.size(), 1);
    tx_en = 1'b1;
    wait_frames("drop_resume", 2, 200);
    repeat (5) @(negedge rdclk);
    chk("drop_rden_after", rden_cnt - r0, 2);
    chk("drop_exp_left", exp_q.size(), 0);

    // reset during bit 3 of 0x3C, then the next byte goes out whole
    do_reset();
    push_byte(8'h3C);
    push_byte(8'($urandom_range(0, 255)));
    tx_en = 1'b1;
    wait_tx_low("abort_start", 50);
    repeat (17) @(negedge rdclk);
    d0 = done_cnt;
    #2500 rdrst = 1'b1;
    #1;
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_tx_done", int'(tx_done), 0);
    chk("abort_frame_cnt", int'(frame_cnt), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (2) @(negedge rdclk);
    chk("abort_no_done", done_cnt - d0, 0);
    #2500 rdrst = 1'b0;
    wait_frames("abort_next_frame", 1, 200);
    repeat (5) @(negedge rdclk);
    chk("abort_done_after", done_cnt - d0, 1);
    chk("abort_exp_left", exp_q.size(), 0);

    // random stream written at wrclk, drained at rdclk
    do_reset();
    r0 = rden_cnt;
    tx_en = 1'b1;
    for (int i = 0; i < 40; i++) push_byte(8'($urandom_range(0, 255)));
    wait_frames("stream_frame_cnt", 40, 40 * 43 + 400);
    repeat (5) @(negedge rdclk);
    chk("stream_rden", rden_cnt - r0, 40);
    chk("stream_exp_left", exp_q.size(), 0);
    chk("stream_fifo_drained", int'(rd_ptr), int'(wr_ptr));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
